// File: rtl/sensor_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_pkg
// Description : Shared types and constants for the sensor frame receiver:
//               parser state encoding, frame TYPE codes, default header byte.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_frame_pkg;

   // Parser state, explicit 2-bit encoding
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TYPE = 2'd1,
      S_DATA = 2'd2,
      S_SUM  = 2'd3
   } state_t;

   localparam logic [7:0] TYP_GEO     = 8'h01;
   localparam logic [7:0] TYP_GPS     = 8'h02;
   localparam logic [7:0] TYP_QR      = 8'h03;
   localparam logic [7:0] HDR_DEFAULT = 8'hA5;

   // True for the three TYPE codes the receiver knows how to commit
   function automatic logic is_legal_type(input logic [7:0] t);
      return (t == TYP_GEO) || (t == TYP_GPS) || (t == TYP_QR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_rx_if
// Description : Byte input strobe and decoded output bundle of the sensor
//               frame receiver. master = byte source / output consumer,
//               slave = the receiver itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface sensor_frame_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] geo_out;
   logic [7:0] gps_out;
   logic       QR_out;
   logic       geo_upd;
   logic       gps_upd;
   logic       frame_err;
   logic [7:0] err_cnt;

   modport master (
      output rx_data, rx_valid,
      input  geo_out, gps_out, QR_out, geo_upd, gps_upd, frame_err, err_cnt
   );

   modport slave (
      input  rx_data, rx_valid,
      output geo_out, gps_out, QR_out, geo_upd, gps_upd, frame_err, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/sensor_frame_rx_qr_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : qr_hold_timer
// Description : Holds the QR-present flag high for QR_HOLD cycles after a
//               load; clear drops it immediately. Counts regardless of the
//               parser enable.
// Revision    : 1.0 - initial release
// ============================================================================
module qr_hold_timer #(
   parameter int QR_HOLD = 50
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic load,
   input  wire logic clear,
   output logic      qr_out
);

   localparam int CNT_W = (QR_HOLD > 1) ? $clog2(QR_HOLD + 1) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             qr_q,  qr_d;

   // Next-value logic: clear beats load; flag falls on the edge the count hits 0
   always_comb begin
      cnt_d = cnt_q;
      qr_d  = qr_q;
      if (clear) begin
         cnt_d = '0;
         qr_d  = 1'b0;
      end else if (load) begin
         cnt_d = CNT_W'(QR_HOLD);
         qr_d  = (QR_HOLD != 0);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            qr_d = 1'b0;
         end
      end
   end

   // Registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         qr_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         qr_q  <= qr_d;
      end
   end

   assign qr_out = qr_q;

endmodule
`default_nettype wire

// File: rtl/sensor_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_rx
// Description : Parses HDR/TYPE/PAYLOAD/SUM sensor frames into registered
//               heading, latitude and QR-present values for the motor
//               controller. Malformed or stalled frames are dropped and
//               counted. Optional macro SENS_CHECKSUM_EN enables the SUM
//               (TYPE ^ PAYLOAD) comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_frame_rx
   import sensor_frame_pkg::*;
#(
   parameter logic [7:0] HDR         = HDR_DEFAULT,
   parameter int         TIMEOUT_CYC = 1000,
   parameter int         QR_HOLD     = 50
) (
   input  wire logic     PWM,
   input  wire logic     RST,
   input  wire logic     EN,
   sensor_frame_rx_if.slave bus
);

   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   state_t           state_q,     state_d;
   logic [7:0]       type_q,      type_d;
   logic [7:0]       payload_q,   payload_d;
   logic [TMO_W-1:0] tmo_q,       tmo_d;
   logic [7:0]       geo_q,       geo_d;
   logic [7:0]       gps_q,       gps_d;
   logic             geo_upd_q,   geo_upd_d;
   logic             gps_upd_q,   gps_upd_d;
   logic             frame_err_q, frame_err_d;
   logic [7:0]       err_cnt_q,   err_cnt_d;

   logic rx_acc;
   logic tmo_hit;
   logic sum_ok;
   logic commit_geo, commit_gps, qr_load, qr_clear, err_evt;

   assign rx_acc  = EN && bus.rx_valid;
   // A byte arriving in the would-be timeout cycle wins, hence !rx_valid
   assign tmo_hit = EN && (state_q != S_IDLE) && !bus.rx_valid &&
                    (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

`ifdef SENS_CHECKSUM_EN
   assign sum_ok = (bus.rx_data == (type_q ^ payload_q));
`else
   assign sum_ok = 1'b1;
`endif

   // FSM state register plus datapath registers, synchronous active-low reset
   always_ff @(posedge PWM) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         type_q      <= '0;
         payload_q   <= '0;
         tmo_q       <= '0;
         geo_q       <= '0;
         gps_q       <= '0;
         geo_upd_q   <= 1'b0;
         gps_upd_q   <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         payload_q   <= payload_d;
         tmo_q       <= tmo_d;
         geo_q       <= geo_d;
         gps_q       <= gps_d;
         geo_upd_q   <= geo_upd_d;
         gps_upd_q   <= gps_upd_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Next-state: only accepted bytes advance; EN low or timeout forces idle
   always_comb begin
      state_d = state_q;
      if (!EN) begin
         state_d = S_IDLE;
      end else if (bus.rx_valid) begin
         case (state_q)
            S_IDLE:  state_d = (bus.rx_data == HDR) ? S_TYPE : S_IDLE;
            S_TYPE:  state_d = is_legal_type(bus.rx_data) ? S_DATA : S_IDLE;
            S_DATA:  state_d = S_SUM;
            S_SUM:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end else if (tmo_hit) begin
         state_d = S_IDLE;
      end
   end

   // FSM outputs: frame outcome events (commit by type, or drop)
   always_comb begin
      commit_geo = 1'b0;
      commit_gps = 1'b0;
      qr_load    = 1'b0;
      qr_clear   = 1'b0;
      err_evt    = 1'b0;
      if (rx_acc) begin
         case (state_q)
            S_TYPE: begin
               if (!is_legal_type(bus.rx_data)) begin
                  err_evt = 1'b1;
               end
            end
            S_SUM: begin
               if (sum_ok) begin
                  case (type_q)
                     TYP_GEO: commit_geo = 1'b1;
                     TYP_GPS: commit_gps = 1'b1;
                     TYP_QR: begin
                        qr_load  = payload_q[0];
                        qr_clear = !payload_q[0];
                     end
                     default: err_evt = 1'b1;
                  endcase
               end else begin
                  err_evt = 1'b1;
               end
            end
            default: ;
         endcase
      end else if (tmo_hit) begin
         err_evt = 1'b1;
      end
   end

   // Datapath next values: field capture, idle timer, outputs, error count
   always_comb begin
      type_d    = type_q;
      payload_d = payload_q;
      if (rx_acc && (state_q == S_TYPE)) begin
         type_d = bus.rx_data;
      end
      if (rx_acc && (state_q == S_DATA)) begin
         payload_d = bus.rx_data;
      end

      if (!EN || bus.rx_valid || (state_q == S_IDLE) || tmo_hit) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end

      geo_d       = commit_geo ? payload_q : geo_q;
      gps_d       = commit_gps ? payload_q : gps_q;
      geo_upd_d   = commit_geo;
      gps_upd_d   = commit_gps;
      frame_err_d = err_evt;
      err_cnt_d   = (err_evt && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   qr_hold_timer #(
      .QR_HOLD (QR_HOLD)
   ) u_qr_hold_timer (
      .clk    (PWM),
      .rst_n  (RST),
      .load   (qr_load),
      .clear  (qr_clear),
      .qr_out (bus.QR_out)
   );

   assign bus.geo_out   = geo_q;
   assign bus.gps_out   = gps_q;
   assign bus.geo_upd   = geo_upd_q;
   assign bus.gps_upd   = gps_upd_q;
   assign bus.frame_err = frame_err_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
